ppu_line_compositor: RTL and testbench

Downstream stage of the PPU assembler. Accepts one fully assembled scanline per line over a valid/ready handshake: a background palette-index line plus per-sprite row data for up to 8 sprites. The line is double-buffered and swapped at end of line. Each pixel is composited (background plus sprites, with priority) and resolved through a 24-bit color palette, producing RGB for the VGA output, which is timed by hcount/vcount.

---
 rtl/ppu_line_compositor.sv | 213 +++++++++++++++++++++
 tb/tb_ppu_line_compositor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_compositor.sv
// ppu_line_compositor: double-buffered scanline compositor for the PPU.
// Takes one assembled line (background indices plus up to 8 sprite rows)
// over a valid/ready handshake, swaps it to the front buffer at end of line,
// composites background and sprites with fixed priority, and resolves the
// result through a double-buffered 8-entry RGB palette.
// Pipeline: hcount/vcount in -> stage 1 (compose) -> stage 2 (palette) -> RGB.
// Optional: define PPU_SPRITE_BEHIND_EN to add per-sprite behind-background.
module ppu_line_compositor #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_TOTAL     = 1600,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [10:0]                     hcount,
  input  logic [9:0]                      vcount,
  input  logic                            vblank,
  input  logic                            line_valid,
  output logic                            line_ready,
  input  logic [1279:0]                   bg_line,
  input  logic [NUM_SPRITES*2*SPRITE_W-1:0] spr_row,
  input  logic [NUM_SPRITES*10-1:0]       spr_x,
  input  logic [NUM_SPRITES-1:0]          spr_en,
`ifdef PPU_SPRITE_BEHIND_EN
  input  logic [NUM_SPRITES-1:0]          spr_behind,
`endif
  input  logic                            pal_we,
  input  logic [2:0]                      pal_addr,
  input  logic [23:0]                     pal_data,
  output logic [7:0]                      VGA_R,
  output logic [7:0]                      VGA_G,
  output logic [7:0]                      VGA_B,
  output logic [7:0]                      underrun_count
);

  localparam int          ROW_W  = 2 * SPRITE_W;
  localparam int          COL_W  = $clog2(SPRITE_W);
  localparam int          ID_W   = $clog2(NUM_SPRITES);
  localparam logic [10:0] SWAP_H = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [10:0] SPR_W  = 11'(SPRITE_W);

  typedef enum logic {EMPTY, FULL} back_state_t;

  back_state_t                       back_state;
  logic [1279:0]                     back_bg,  front_bg;
  logic [NUM_SPRITES*ROW_W-1:0]      back_row, front_row;
  logic [NUM_SPRITES*10-1:0]         back_x,   front_x;
  logic [NUM_SPRITES-1:0]            back_en,  front_en;
`ifdef PPU_SPRITE_BEHIND_EN
  logic [NUM_SPRITES-1:0]            back_behind, front_behind;
`endif

  logic [23:0] pal_shadow [8];
  logic [23:0] pal_act    [8];
  logic        vblank_q;

  logic        swap;
  logic [9:0]  x_c;
  logic        act_c;
  logic [1:0]  bg_c;
  logic        hit_c;
  logic [1:0]  spix_c;
  logic [10:0] xe, sx;
  logic [COL_W-1:0] col;
  logic [1:0]  pix;
`ifdef PPU_SPRITE_BEHIND_EN
  logic [ID_W-1:0] win_c;
`endif

  logic        vld_p1;
  logic [1:0]  bg_p1;
  logic        hit_p1;
  logic [1:0]  spix_p1;
  logic [23:0] rgb_p2;

  // Palette entry: sprites use 4..7, background uses 0..3.
  function automatic logic [2:0] pal_entry(input logic hit, input logic [1:0] spix,
                                           input logic [1:0] bg);
    return hit ? {1'b1, spix} : {1'b0, bg};
  endfunction

  assign swap       = (hcount == SWAP_H);
  assign line_ready = (back_state == EMPTY);

  // Back-buffer capture, end-of-line swap/bypass, and underrun accounting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_state     <= EMPTY;
      back_bg        <= '0;
      back_row       <= '0;
      back_x         <= '0;
      back_en        <= '0;
      front_bg       <= '0;
      front_row      <= '0;
      front_x        <= '0;
      front_en       <= '0;
`ifdef PPU_SPRITE_BEHIND_EN
      back_behind    <= '0;
      front_behind   <= '0;
`endif
      underrun_count <= '0;
    end else if (swap) begin
      if (back_state == FULL) begin
        front_bg     <= back_bg;
        front_row    <= back_row;
        front_x      <= back_x;
        front_en     <= back_en;
`ifdef PPU_SPRITE_BEHIND_EN
        front_behind <= back_behind;
`endif
        back_state   <= EMPTY;
      end else if (line_valid) begin
        // Late arrival: line lands straight in the front buffer.
        front_bg     <= bg_line;
        front_row    <= spr_row;
        front_x      <= spr_x;
        front_en     <= spr_en;
`ifdef PPU_SPRITE_BEHIND_EN
        front_behind <= spr_behind;
`endif
      end else if (!vblank && underrun_count != 8'hFF) begin
        underrun_count <= underrun_count + 8'd1;
      end
    end else if (back_state == EMPTY && line_valid) begin
      back_bg      <= bg_line;
      back_row     <= spr_row;
      back_x       <= spr_x;
      back_en      <= spr_en;
`ifdef PPU_SPRITE_BEHIND_EN
      back_behind  <= spr_behind;
`endif
      back_state   <= FULL;
    end
  end

  // Shadow palette writes; shadow (plus same-cycle write) copies to active on vblank rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        pal_shadow[k] <= '0;
        pal_act[k]    <= '0;
      end
    end else begin
      vblank_q <= vblank;
      if (pal_we) pal_shadow[pal_addr] <= pal_data;
      if (vblank && !vblank_q) begin
        for (int k = 0; k < 8; k++)
          pal_act[k] <= (pal_we && pal_addr == 3'(k)) ? pal_data : pal_shadow[k];
      end
    end
  end

  // Composite the current pixel: lowest-index opaque sprite wins over background.
  always_comb begin
    x_c    = hcount[10:1];
    act_c  = (hcount < H_ACT) && (vcount < V_ACT);
    bg_c   = front_bg[{x_c, 1'b0} +: 2];
    xe     = {1'b0, x_c};
    hit_c  = 1'b0;
    spix_c = 2'b00;
    sx     = '0;
    col    = '0;
    pix    = 2'b00;
`ifdef PPU_SPRITE_BEHIND_EN
    win_c  = '0;
`endif
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      sx  = {1'b0, front_x[10*i +: 10]};
      col = COL_W'(xe - sx);
      pix = front_row[ROW_W*i + 2*int'(col) +: 2];
      if (front_en[i] && xe >= sx && xe < sx + SPR_W && pix != 2'b00) begin
        hit_c  = 1'b1;
        spix_c = pix;
`ifdef PPU_SPRITE_BEHIND_EN
        win_c  = ID_W'(i);
`endif
      end
    end
`ifdef PPU_SPRITE_BEHIND_EN
    // Behind sprite only shows through background index 0; no fallback to lower sprites.
    if (hit_c && front_behind[win_c] && bg_c != 2'b00) hit_c = 1'b0;
`endif
  end

  // ---- stage 1: composed pixel ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= act_c;
  end

  // Stage 1 data registers carry no reset; vld_p1 gates them.
  always_ff @(posedge clk) begin
    bg_p1   <= bg_c;
    hit_p1  <= hit_c;
    spix_p1 <= spix_c;
  end

  // ---- stage 2: palette lookup ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_p2 <= '0;
    else       rgb_p2 <= vld_p1 ? pal_act[pal_entry(hit_p1, spix_p1, bg_p1)] : 24'h0;
  end

  assign VGA_R = rgb_p2[23:16];
  assign VGA_G = rgb_p2[15:8];
  assign VGA_B = rgb_p2[7:0];

endmodule

// File: tb/tb_ppu_line_compositor.sv
// Directed bench for ppu_line_compositor: palette double-buffering, sprite
// hit/priority/clipping, underrun counting and saturation, bypass, async reset.
module tb_ppu_line_compositor;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   hcount = 11'd1300;
  logic [9:0]    vcount = 10'd0;
  logic          vblank = 1'b0;
  logic          line_valid = 1'b0;
  logic          line_ready;
  logic [1279:0] bg_line = '0;
  logic [255:0]  spr_row = '0;
  logic [79:0]   spr_x = '0;
  logic [7:0]    spr_en = '0;
`ifdef PPU_SPRITE_BEHIND_EN
  logic [7:0]    spr_behind = '0;
`endif
  logic          pal_we = 1'b0;
  logic [2:0]    pal_addr = '0;
  logic [23:0]   pal_data = '0;
  logic [7:0]    VGA_R, VGA_G, VGA_B;
  logic [7:0]    underrun_count;

  int n_asserts = 0;
  int n_fail    = 0;

  ppu_line_compositor dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .vblank(vblank),
    .line_valid(line_valid), .line_ready(line_ready), .bg_line(bg_line),
    .spr_row(spr_row), .spr_x(spr_x), .spr_en(spr_en),
`ifdef PPU_SPRITE_BEHIND_EN
    .spr_behind(spr_behind),
`endif
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a negedge.
  task automatic pal_write(input logic [2:0] a, input logic [23:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    @(negedge clk);
    pal_we = 1'b0;
  endtask

  task automatic vblank_pulse();
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_line();
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
  endtask

  task automatic do_swap(input int n);
    hcount = 11'd1599;
    repeat (n) @(negedge clk);
    hcount = 11'd1300;
  endtask

  // Present h for one cycle, then park on an inactive count; sample 2 clocks later.
  task automatic px(input string tag, input int h, input int v, input logic [23:0] exp);
    hcount = 11'(h);
    vcount = 10'(v);
    @(negedge clk);
    hcount = 11'd1300;
    @(negedge clk);
    chk(tag, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(line_ready), 32'd1);
    chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);

    // Palette shadowing: write mid-frame, visible only after vblank rise.
    pal_write(3'd1, 24'hFF0000);
    bg_line = {640{2'b01}};
    load_line();
    chk("load_not_ready", 32'(line_ready), 32'd0);
    do_swap(1);
    chk("swap_ready", 32'(line_ready), 32'd1);
    px("pal_pre_x0", 0, 0, 24'h000000);
    px("pal_pre_x639", 1279, 10, 24'h000000);
    vblank_pulse();
    px("pal_post_x5", 10, 5, 24'hFF0000);
    px("pal_post_last", 1279, 479, 24'hFF0000);
    px("inactive_h", 1280, 5, 24'h000000);
    px("inactive_v", 10, 480, 24'h000000);

    // Single sprite, column 0 opaque over bg index 0.
    pal_write(3'd6, 24'h00FF00);
    pal_write(3'd0, 24'h000010);
    vblank_pulse();
    bg_line = '0;
    spr_row = '0; spr_row[31:0] = 32'h0000_0002;
    spr_x = '0;   spr_x[9:0] = 10'd100;
    spr_en = 8'b0000_0001;
    load_line();
    do_swap(1);
    px("spr_h200", 200, 20, 24'h00FF00);
    px("spr_h201", 201, 20, 24'h00FF00);
    px("spr_x99", 198, 20, 24'h000010);
    px("spr_x101", 202, 20, 24'h000010);

    // Priority between sprites 0 and 3.
    pal_write(3'd5, 24'h123456);
    pal_write(3'd7, 24'hABCDEF);
    pal_write(3'd3, 24'h333333);
    vblank_pulse();
    bg_line = '0;
    spr_row = '0;
    spr_row[31:0]   = 32'h0000_0001;
    spr_row[127:96] = 32'h0000_0C00;
    spr_x = '0; spr_x[9:0] = 10'd50; spr_x[39:30] = 10'd45;
    spr_en = 8'b0000_1001;
    load_line();
    do_swap(1);
    px("prio_spr0", 100, 30, 24'h123456);

    // Sprite 0 transparent there, sprite 1 clipped at right edge, sprite 2 disabled.
    bg_line = {640{2'b11}};
    spr_row = '0;
    spr_row[63:32]  = 32'h0004_0000;
    spr_row[95:64]  = 32'hFFFF_FFFF;
    spr_row[127:96] = 32'h0000_0C00;
    spr_x = '0;
    spr_x[9:0] = 10'd50; spr_x[19:10] = 10'd630; spr_x[29:20] = 10'd200; spr_x[39:30] = 10'd45;
    spr_en = 8'b0000_1011;
    load_line();
    do_swap(1);
    px("prio_spr3", 100, 40, 24'hABCDEF);
    px("clip_x639", 1278, 40, 24'h123456);
    px("bg_x629", 1258, 40, 24'h333333);
    px("spr_disabled", 400, 40, 24'h333333);

    // Underrun: one visible miss, then a miss during vblank.
    chk("underrun_zero", 32'(underrun_count), 32'd0);
    do_swap(1);
    chk("underrun_one", 32'(underrun_count), 32'd1);
    px("line_repeat", 100, 41, 24'hABCDEF);
    vblank = 1'b1;
    do_swap(1);
    vblank = 1'b0;
    @(negedge clk);
    chk("underrun_vblank", 32'(underrun_count), 32'd1);

    // Bypass: valid arrives exactly at the swap point with back empty.
    bg_line = {640{2'b01}};
    spr_row = '0; spr_x = '0; spr_en = '0;
    hcount = 11'd1599;
    line_valid = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    hcount = 11'd1300;
    chk("bypass_underrun", 32'(underrun_count), 32'd1);
    chk("bypass_ready", 32'(line_ready), 32'd1);
    px("bypass_pixel", 100, 42, 24'hFF0000);

    // Saturation.
    do_swap(100);
    chk("underrun_101", 32'(underrun_count), 32'd101);
    do_swap(200);
    chk("underrun_sat", 32'(underrun_count), 32'd255);
    do_swap(5);
    chk("underrun_hold", 32'(underrun_count), 32'd255);

    // Asynchronous reset mid-line with a full back buffer and live RGB.
    bg_line = {640{2'b10}};
    load_line();
    chk("pre_rst_ready", 32'(line_ready), 32'd0);
    hcount = 11'd100;
    vcount = 10'd50;
    repeat (2) @(negedge clk);
    chk("pre_rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h00FF0000);
    #2 reset = 1'b1;
    #1;
    chk("async_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    chk("async_ready", 32'(line_ready), 32'd1);
    chk("async_underrun", 32'(underrun_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    px("post_rst_pal", 100, 50, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
